// File: rtl/mul_add_row_pkg.sv
// rtl/mul_add_row_pkg.sv - shared word width and FSM state encodings for mul_add_row
//
// Purpose: holds the default datapath word width and the row FSM state
// encodings, so the top level and any future users agree on them.
package mul_add_row_pkg;

  // Default word width W used when the instantiating design does not override it.
  localparam int DATA_WIDTH = 32;

  // Row FSM state encodings.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/mul_add_row_mul_pipe.sv
// rtl/mul_add_row_mul_pipe.sv - LAT-stage registered x*y+z with valid/last shift chain
//
// Purpose: computes p = x*y + z at 2W bits.
// - Stage 0 registers the product-sum.
// - Stages 1..LAT-1 are plain delay registers.
// A valid bit and a last-word tag travel with every stage.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_last    operand word valid / word is the last of the row
//   x, y, z   [W-1:0]    operands
//   out_valid, out_last  valid / last tag of the stage LAT-1 word
//   p_out     [2W-1:0]   x*y+z of the stage LAT-1 word
module mul_pipe #(
  parameter int W   = mul_add_row_pkg::DATA_WIDTH,
  parameter int LAT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic           in_last,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  input  logic [W-1:0]   z,
  output logic           out_valid,
  output logic           out_last,
  output logic [2*W-1:0] p_out
);

  logic [2*W-1:0] p_q [LAT];
  logic [LAT-1:0] v_q;
  logic [LAT-1:0] l_q;
  logic [2*W-1:0] p_d;

  // (2^W-1)^2 + (2^W-1) fits in 2W bits, so no extra bit is needed.
  assign p_d = (2*W)'(x) * (2*W)'(y) + (2*W)'(z);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      l_q <= '0;
      for (int i = 0; i < LAT; i++) p_q[i] <= '0;
    end else begin
      v_q[0] <= in_valid;
      l_q[0] <= in_valid && in_last;
      p_q[0] <= p_d;
      for (int i = 1; i < LAT; i++) begin
        v_q[i] <= v_q[i-1];
        l_q[i] <= l_q[i-1];
        p_q[i] <= p_q[i-1];
      end
    end
  end

  assign out_valid = v_q[LAT-1];
  assign out_last  = l_q[LAT-1];
  assign p_out     = p_q[LAT-1];

endmodule

// File: rtl/mul_add_row.sv
// rtl/mul_add_row.sv - pipelined multiply-accumulate row engine (s_i = x*y_i + z_i + c)
//
// Purpose: streams NUM_WORDS (y,z) word pairs through a MUL_LAT-stage
// x*y+z pipeline. A final registered adder adds the running carry to each
// word, emits the low word and keeps the high word as the next carry.
//
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   start, x, carry_in        begin a row (IDLE only), scalar, initial carry
//   busy                      high outside IDLE
//   in_valid, in_ready        operand handshake (in_ready high in RUN only)
//   y_in, z_in                operand words, least-significant first
//   out_valid, s_out, out_last  result word stream, no backpressure
//   done, carry_out           end-of-row pulse and final carry
module mul_add_row #(
  parameter int DATA_WIDTH = mul_add_row_pkg::DATA_WIDTH,
  parameter int NUM_WORDS  = 128,
  parameter int MUL_LAT    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] carry_in,
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] y_in,
  input  logic [DATA_WIDTH-1:0] z_in,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] s_out,
  output logic                  out_last,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] carry_out
);
  import mul_add_row_pkg::*;

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(NUM_WORDS + 1);

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   x_q, c_q, s_q, carry_out_q;
  logic           busy_q, in_ready_q, done_q, out_valid_q, out_last_q;

  logic           start_ok, accept, last_word;
  logic           pv, pl;
  logic [2*W-1:0] pp, t;

  assign start_ok  = start && (state_q == ST_IDLE);
  assign accept    = in_valid && (state_q == ST_RUN);
  assign last_word = accept && (cnt_q == CW'(NUM_WORDS - 1));

  mul_pipe #(
    .W   (W),
    .LAT (MUL_LAT)
  ) u_mul_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (accept),
    .in_last   (last_word),
    .x         (x_q),
    .y         (y_in),
    .z         (z_in),
    .out_valid (pv),
    .out_last  (pl),
    .p_out     (pp)
  );

  // Final adder: the only stage inside the carry loop, so the loop is one cycle.
  assign t = pp + {{W{1'b0}}, c_q};

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_RUN;
      ST_RUN:   if (last_word) state_d = ST_DRAIN;
      // The last word is being emitted this cycle, so the pipeline is empty.
      ST_DRAIN: if (out_last_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      c_q         <= '0;
      s_q         <= '0;
      carry_out_q <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // Status outputs are registered from the next state so they line up with it.
      busy_q     <= (state_d != ST_IDLE);
      in_ready_q <= (state_d == ST_RUN);
      done_q     <= (state_d == ST_DONE);

      if (start_ok) begin
        x_q   <= x;
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + CW'(1);
      end

      // Bubbles leave the carry untouched.
      if (start_ok)  c_q <= carry_in;
      else if (pv)   c_q <= t[2*W-1:W];

      out_valid_q <= pv;
      out_last_q  <= pv && pl;
      if (pv)       s_q <= t[W-1:0];
      if (pv && pl) carry_out_q <= t[2*W-1:W];
    end
  end

  assign busy      = busy_q;
  assign in_ready  = in_ready_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign s_out     = s_q;
  assign carry_out = carry_out_q;

endmodule

// File: tb/tb_mul_add_row.sv
// tb/tb_mul_add_row.sv - scoreboard testbench for mul_add_row (W=8, 4 words, 2 mul stages)
module tb_mul_add_row;

  localparam int W = 8;
  localparam int N = 4;
  localparam int L = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] x, carry_in, y_in, z_in;
  logic         busy, in_valid, in_ready, out_valid, out_last, done;
  logic [W-1:0] s_out, carry_out;

  mul_add_row #(
    .DATA_WIDTH (W),
    .NUM_WORDS  (N),
    .MUL_LAT    (L)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .x         (x),
    .carry_in  (carry_in),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_in      (y_in),
    .z_in      (z_in),
    .out_valid (out_valid),
    .s_out     (s_out),
    .out_last  (out_last),
    .done      (done),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] s;
    logic         last;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           exp_done = -1;
  logic [W-1:0] exp_carry = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every out_valid and checks value,
  // last flag and latency; then checks done/carry_out one cycle after the last word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        chk("sb_nonempty", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("s_out", s_out, e.s);
          chk("out_last", out_last, e.last);
          chk("latency", cyc, e.cyc + L + 1);
          if (e.last) exp_done = cyc + 1;
        end
      end
      if (exp_done >= 0 && cyc == exp_done) begin
        chk("done_pulse", done, 1);
        chk("carry_out", carry_out, exp_carry);
        exp_done = -1;
      end else begin
        chk("done_quiet", done, 0);
      end
    end
  end

  task automatic run_row(input logic [W-1:0] xv, input logic [W-1:0] cv,
                         input logic [4*W-1:0] ys, input logic [4*W-1:0] zs,
                         input bit bubbles, input bit mid_start);
    logic [2*W-1:0] t;
    logic [W-1:0]   c;
    logic [W-1:0]   yv, zv;
    int             k;
    int             budget;
    bit             toggle;
    k = 0; budget = 0; toggle = 1'b1;
    c = cv;
    @(negedge clk);
    start = 1'b1; x = xv; carry_in = cv;
    @(negedge clk);
    start = 1'b0; x = '0; carry_in = '0;
    chk("busy_after_start", busy, 1);
    while (k < N && budget < 40) begin
      yv = ys[k*W +: W];
      zv = zs[k*W +: W];
      in_valid = bubbles ? toggle : 1'b1;
      toggle = ~toggle;
      y_in = yv; z_in = zv;
      if (mid_start && k == 1) begin
        start = 1'b1; x = 8'h07; carry_in = 8'h33;
      end else begin
        start = 1'b0; x = '0; carry_in = '0;
      end
      if (in_valid && in_ready) begin
        t = (2*W)'(xv) * (2*W)'(yv) + (2*W)'(zv) + (2*W)'(c);
        c = t[2*W-1:W];
        sb.push_back('{s: t[W-1:0], last: (k == N-1), cyc: cyc});
        if (k == N-1) exp_carry = t[2*W-1:W];
        k++;
      end
      @(negedge clk);
      budget++;
    end
    in_valid = 1'b0; start = 1'b0; x = '0; carry_in = '0;
    chk("row_accepted", k, N);
    repeat (6) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    chk("done_seen", exp_done, -1);
    chk("idle_busy", busy, 0);
    chk("idle_in_ready", in_ready, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    x = '0; carry_in = '0; y_in = '0; z_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_s_out", s_out, 0);
    chk("rst_carry_out", carry_out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic row, carry ripple, max operands, bubbles, ignored start while busy.
    run_row(8'h02, 8'h00, 32'h04030201, 32'h00000000, 1'b0, 1'b0);
    chk("basic_carry", carry_out, 8'h00);
    run_row(8'h10, 8'h00, 32'h10101010, 32'h00000000, 1'b0, 1'b0);
    chk("ripple_carry", carry_out, 8'h01);
    run_row(8'hFF, 8'hFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    chk("max_carry", carry_out, 8'hFF);
    run_row(8'h02, 8'h00, 32'h04030201, 32'h00000000, 1'b1, 1'b0);
    run_row(8'h02, 8'h00, 32'h04030201, 32'h00000000, 1'b0, 1'b1);
    chk("midstart_carry", carry_out, 8'h00);

    // Reset mid-row: two words in, then reset before any output appears.
    @(negedge clk);
    start = 1'b1; x = 8'h02; carry_in = 8'h00;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; y_in = 8'h01; z_in = 8'h00;
    @(negedge clk);
    y_in = 8'h02;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_done", done, 0);
    chk("midrst_s_out", s_out, 0);
    chk("midrst_carry_out", carry_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_quiet", out_valid, 0);
    run_row(8'h02, 8'h00, 32'h04030201, 32'h00000000, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_add_row.md
# mul_add_row

Pipelined, parametrised multiply-accumulate row engine for MonPro. Given one scalar word `x`, an optional starting carry and a stream of `NUM_WORDS` word pairs (y_i, z_i), it emits s_i = low word of (x·y_i + z_i + c_{i-1}) and carries the high word into the next word, one word per cycle. Its final carry is reported at the end of the row. It replaces the single-word combinational mul-add inside the CIOS inner loop, so a full 4096-bit row runs as a streamed, clock-rate pipeline.

## Interface
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (shared parameter file), word width W.
- `NUM_WORDS`, default 128, words per row. Legal range is ≥1.
- `MUL_LAT`, default 2, number of register stages in the multiply/add-z pipeline. Legal range is ≥1.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a row. Accepted only in IDLE.
- `x`  in  W  scalar multiplicand, sampled at the accepted `start`.
- `carry_in`  in  W  initial carry c_{-1}, sampled at the accepted `start`.
- `busy`  out  1  high in every state other than IDLE.
- `in_valid`  in  1  y_in/z_in valid.
- `in_ready`  out  1  high in RUN only.
- `y_in`, `z_in`  in  W each  operand words, least-significant word first.
- `out_valid`  out  1  s_out valid. One-cycle pulse per word; there is no backpressure.
- `s_out`  out  W  result word.
- `out_last`  out  1  high together with `out_valid` on word NUM_WORDS-1.
- `done`  out  1  one-cycle pulse after the last word.
- `carry_out`  out  W  final carry. Valid from `done` and held until the next accepted `start`.

## Operation
- FSM states and transitions:
  - IDLE → RUN on `start`.
  - RUN → DRAIN on the edge accepting word NUM_WORDS-1.
  - DRAIN → DONE when the pipeline is empty and the last word has been emitted.
  - DONE → IDLE unconditionally. `done` is high in DONE.
- On the accepted `start`: latch `x`; load the carry register with `carry_in`; clear the word counter of width $clog2(NUM_WORDS+1).
- Input handshake:
  - A word is accepted on an edge where `in_valid && in_ready` is high.
  - The counter increments per accepted word.
  - `in_valid` outside RUN is ignored.
- Pipeline datapath:
  - Stages 1..MUL_LAT compute p_i = x·y_i + z_i at width 2W.
  - The final stage computes t = p_i + c, with c being the carry register. It then sets s_out = t[W-1:0] and c ← t[2W-1:W].
  - Width bound: (2^W−1)² + 2(2^W−1) = 2^{2W}−1, so no overflow bit is kept.
- The carry feedback is closed only around the final adder. This gives one word per cycle and a single-cycle carry loop.
- A valid bit travels alongside each stage. Bubbles (`in_valid` low in RUN) propagate as invalid stages and do not update the carry register.
- `start` while `busy` is ignored, with no effect on the current row.
- NUM_WORDS=1: RUN lasts until one word is accepted, and that word carries `out_last`.
- Reset values: state IDLE, all pipeline valids 0. `busy`, `in_ready`, `out_valid`, `out_last` and `done` are 0. `s_out`, `carry_out` and the internal x/carry registers are 0.
- Reset mid-row: the row is abandoned with no partial `done`. After release the block is in IDLE and the next `start` runs cleanly.

## Timing
- Latency: a word handshaken in cycle k appears with `out_valid` in cycle k+MUL_LAT+1. Example: MUL_LAT=2, accepted in cycle 0, output in cycle 3.
- `done` and a valid `carry_out` are asserted in the cycle after the `out_last` cycle.
- `busy` is high from the cycle after the accepted `start` through the DONE cycle.
- A new `start` is accepted no earlier than the cycle after DONE.
- Throughput is 1 word/cycle with `in_valid` held high. A row takes NUM_WORDS + MUL_LAT + 3 cycles from `start` to the end of `done`.
- All outputs are registered.

## Structure
- Shared parameter file: `DATA_WIDTH` and the FSM state encodings (IDLE/RUN/DRAIN/DONE) as localparam constants.
- Sub-module `mul_pipe`: a MUL_LAT-stage registered x·y+z (2W-bit) with a valid shift chain. The top level holds the FSM, counter, carry register and final adder.

## Test plan
Bench uses DATA_WIDTH=8, NUM_WORDS=4, MUL_LAT=2.
- Basic row: x=2, y={1,2,3,4}, z=0, carry_in=0 → s_out={02,04,06,08}, `out_last` on the 4th word, carry_out=00, `done` one cycle later.
- Carry ripple: x=0x10, y all 0x10, z=0, carry_in=0 → s_out={00,01,01,01}, carry_out=01.
- Max operands: x, y, z and carry_in all 0xFF → every s_out=FF, carry_out=FF, no overflow.
- Bubbles: basic row with `in_valid` low every other cycle → same s_out values, `out_valid` gaps match the input gaps, and each output lands exactly 3 cycles after its handshake.
- Start while busy: second `start` (x=7) mid-row → ignored, results match x=2. Reset mid-row: `rst_n` low after 2 words → all outputs 0, IDLE; a subsequent basic row gives the correct results.
